// File: rtl/rst_seq_xil7series.sv
// Board-level reset sequencer for a Xilinx 7-series clock generator.
// Pulses the PLL/MMCM reset, waits for lock with a timeout and retry,
// holds the SoC in reset until lock has been stable long enough, then
// releases it. A debounced button press, a software request or a lock
// loss re-runs the relevant part of the sequence.
//
// Parameter constraints, which are not checked here:
//   PLL_RST_CYCLES >= 1, LOCK_TIMEOUT >= 2, STABLE_CYCLES >= 1,
//   DEBOUNCE_CYCLES >= 1, and 2**CNT_W must exceed each of them.
module rst_seq_xil7series #(
    parameter int unsigned PLL_RST_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 4096,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ext_rst_ni,
    input  logic       sw_rst_req_i,
    input  logic       pll_locked_i,
    output logic       pll_rst_o,
    output logic       rst_sys_no,
    output logic       rst_done_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
);

    // Terminal counts. Every dwell ends on equality with PARAM-1, so a
    // parameter of 1 gives a one-cycle stay and the counter never wraps.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The encoding is visible on state_o, so it is fixed here explicitly.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic btn_meta;
    logic btn_sync;
    logic lock_meta;
    logic lock_sync;

    // Two-flop synchronizers. They reset to "button released, not locked".
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two
    // synchronizer stages into a single flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_meta  <= 1'b1;
            btn_sync  <= 1'b1;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            btn_meta  <= ext_rst_ni;
            btn_sync  <= btn_meta;
            lock_meta <= pll_locked_i;
            lock_sync <= lock_meta;
        end
    end

    logic             btn_db;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_req;

    // Debouncer: the filtered level follows the synchronized button only
    // after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_sync != btn_db) begin
            if (db_cnt == DEBOUNCE_LAST) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // The button is active-low: a debounced low level is a reset request.
    assign btn_req = ~btn_db;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       retry_q;
    logic [3:0]       retry_d;
    logic [3:0]       retry_sat;

    assign retry_sat = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    // Next-state, counter and retry logic. Lock loss outranks a reset
    // request, which outranks counter expiry.
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement leaves one unassigned and no latch forms.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                if (lock_sync) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    retry_d = retry_sat;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STABLE: begin
                if (!lock_sync) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                cnt_d = '0;
                if (!lock_sync) begin
                    state_d = ST_PLL_RST;
                end else if (btn_req || sw_rst_req_i) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // The stable dwell only starts once the button is released;
                // a renewed press restarts it. Software requests are
                // already being served here and are dropped.
                if (!lock_sync) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else if (btn_req) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    logic pll_rst_q;
    logic rst_sys_nq;
    logic rst_done_q;

    // State register plus output flops decoded from the next state, so the
    // reset lines are glitch-free and change together with state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            retry_q    <= 4'd0;
            pll_rst_q  <= 1'b1;
            rst_sys_nq <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            pll_rst_q  <= (state_d == ST_PLL_RST);
            rst_sys_nq <= (state_d == ST_RUN);
            rst_done_q <= (state_d == ST_RUN);
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign rst_sys_no  = rst_sys_nq;
    assign rst_done_o  = rst_done_q;
    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rst_seq_xil7series.sv
// Self-checking bench for rst_seq_xil7series: directed scenarios followed
// by random stimulus, every cycle compared against a behavioural model.
module tb_rst_seq_xil7series;

    localparam int PLL_N = 4;
    localparam int TMO_N = 32;
    localparam int STB_N = 8;
    localparam int DB_N  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_n;
    logic       sw;
    logic       lock;
    logic       pll_rst_o;
    logic       rst_sys_no;
    logic       rst_done_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;

    rst_seq_xil7series #(
        .PLL_RST_CYCLES (PLL_N),
        .LOCK_TIMEOUT   (TMO_N),
        .STABLE_CYCLES  (STB_N),
        .DEBOUNCE_CYCLES(DB_N),
        .CNT_W          (20)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ext_rst_ni  (ext_n),
        .sw_rst_req_i(sw),
        .pll_locked_i(lock),
        .pll_rst_o   (pll_rst_o),
        .rst_sys_no  (rst_sys_no),
        .rst_done_o  (rst_done_o),
        .retry_cnt_o (retry_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase numbers follow the published state encoding,
    // "age" is the number of cycles already spent in the current phase.
    // ------------------------------------------------------------------
    int m_phase, m_age, m_retry, m_run;
    bit lk1, lk2, bt1, bt2, m_db;

    task automatic go(input int ph);
        m_phase = ph;
        m_age   = 0;
    endtask

    task automatic model_step();
        bit lock_seen;
        bit btn_down;
        if (rst) begin
            go(0);
            m_retry = 0;
            lk1 = 0; lk2 = 0; bt1 = 1; bt2 = 1; m_db = 1; m_run = 0;
            return;
        end
        // What the sequencer sees this cycle: inputs delayed by two flops,
        // button filtered by the debouncer.
        lock_seen = lk2;
        btn_down  = !m_db;
        if (bt2 != m_db) begin
            m_run++;
            if (m_run == DB_N) begin
                m_db  = bt2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        lk2 = lk1; lk1 = lock;
        bt2 = bt1; bt1 = ext_n;

        case (m_phase)
            0: if (m_age + 1 == PLL_N) go(1); else m_age++;
            1: if (lock_seen) go(2);
               else if (m_age + 1 == TMO_N) begin
                   go(0);
                   if (m_retry < 15) m_retry++;
               end else m_age++;
            2: if (!lock_seen) go(1);
               else if (m_age + 1 == STB_N) begin
                   go(3);
                   m_retry = 0;
               end else m_age++;
            3: if (!lock_seen) go(0);
               else if (btn_down || sw) go(4);
            4: if (!lock_seen) go(0);
               else if (btn_down) m_age = 0;
               else if (m_age + 1 == STB_N) go(3);
               else m_age++;
            default: go(0);
        endcase
    endtask

    // One clock: the model advances on the edge, outputs are compared on
    // the falling edge, where the caller then drives new inputs.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pll_rst",   pll_rst_o,   m_phase == 0);
        check("rst_sys_n", rst_sys_no,  m_phase == 3);
        check("rst_done",  rst_done_o,  m_phase == 3);
        check("retry",     retry_cnt_o, m_retry);
        check("state",     state_o,     m_phase);
    endtask

    task automatic apply_reset();
        rst = 1; ext_n = 1; sw = 0; lock = 0;
        repeat (3) cycle();
        check("rst_state_pll", pll_rst_o, 1);
        check("rst_state_sys", rst_sys_no, 0);
        check("rst_state_st", state_o, 0);
        rst = 0;
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int n = 0;
        while (state_o != 3'(target) && n < budget) begin
            cycle();
            n++;
        end
        if (state_o != 3'(target)) check({tag, "_timeout"}, state_o, target);
    endtask

    initial begin
        int pll_hi, rise, rises, low, k;
        bit prev, pll_seen;
        int seq[$];

        // Cold start, lock applied in cycle 10 after reset release.
        apply_reset();
        pll_hi = pll_rst_o ? 1 : 0;
        rise = -1;
        for (int c = 0; c < 40; c++) begin
            lock = (c >= 10);
            cycle();
            if (pll_rst_o) pll_hi++;
            if (rst_sys_no && rise < 0) rise = c + 1;
        end
        check("cold_pll_len", pll_hi, PLL_N);
        // Two synchronizer stages, one decision edge, then the stable dwell.
        check("cold_release_at", rise, 10 + 2 + 1 + STB_N);
        check("cold_done", rst_done_o, 1);
        check("cold_retry", retry_cnt_o, 0);

        // No lock: re-pulse period and retry count.
        apply_reset();
        prev = 1;
        rises = 0;
        for (int c = 1; c <= 120; c++) begin
            cycle();
            if (pll_rst_o && !prev) begin
                rises++;
                check("repulse_at", c, rises * (PLL_N + TMO_N));
                check("retry_seq", retry_cnt_o, rises);
            end
            prev = pll_rst_o;
        end
        check("repulse_count", rises, 3);
        lock = 1;
        wait_state(3, 200, "lock_late");
        check("retry_cleared", retry_cnt_o, 0);

        // Single-cycle software request in RUN.
        sw = 1;
        cycle();
        sw = 0;
        check("sw_drop_next", rst_sys_no, 0);
        low = 0;
        pll_seen = 0;
        while (!rst_sys_no && low < 50) begin
            low++;
            if (pll_rst_o) pll_seen = 1;
            cycle();
        end
        if (pll_rst_o) pll_seen = 1;
        check("sw_low_len", low, STB_N);
        check("sw_no_pll", pll_seen, 0);

        // Three-cycle glitch on the button is filtered out.
        low = 0;
        ext_n = 0;
        repeat (3) cycle();
        ext_n = 1;
        repeat (30) begin
            cycle();
            if (!rst_sys_no) low++;
        end
        check("glitch_no_reset", low, 0);

        // Twenty-cycle press: front and back filtering latencies cancel,
        // leaving the press, the stable dwell and one lost decision edge.
        low = 0;
        ext_n = 0;
        repeat (20) begin
            cycle();
            if (!rst_sys_no) low++;
        end
        ext_n = 1;
        k = 0;
        while (k < 80) begin
            cycle();
            if (!rst_sys_no) low++;
            k++;
        end
        check("press_low_len", low, 20 + STB_N - 1);
        check("press_back_run", state_o, 3);

        // One-cycle lock drop in RUN.
        lock = 0;
        cycle();
        lock = 1;
        k = 1;
        while (state_o != 3'd0 && k < 20) begin
            cycle();
            k++;
        end
        check("lockloss_latency", k, 3);
        seq.delete();
        seq.push_back(int'(state_o));
        k = 0;
        while (state_o != 3'd3 && k < 200) begin
            cycle();
            if (int'(state_o) != seq[$]) seq.push_back(int'(state_o));
            k++;
        end
        check("walk_len", seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++) check("walk_state", seq[i], i);

        // rst_i while in STABLE.
        lock = 0;
        cycle();
        lock = 1;
        wait_state(2, 100, "reach_stable");
        rst = 1;
        cycle();
        check("stable_rst_pll", pll_rst_o, 1);
        check("stable_rst_sys", rst_sys_no, 0);
        check("stable_rst_st", state_o, 0);
        rst = 0;
        wait_state(3, 200, "restart");
        check("restart_done", rst_done_o, 1);

        // Retry counter saturation.
        lock = 0;
        repeat (17 * (PLL_N + TMO_N)) cycle();
        check("retry_sat", retry_cnt_o, 15);
        lock = 1;
        wait_state(3, 200, "after_sat");
        check("retry_sat_clear", retry_cnt_o, 0);

        // Random stimulus against the model.
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 5))
                0: repeat ($urandom_range(1, 20)) cycle();
                1: begin
                    lock = 0;
                    repeat ($urandom_range(1, 6)) cycle();
                    lock = 1;
                end
                2: begin
                    ext_n = 0;
                    repeat ($urandom_range(1, 25)) cycle();
                    ext_n = 1;
                end
                3: begin
                    sw = 1;
                    cycle();
                    sw = 0;
                end
                4: begin
                    rst = 1;
                    repeat ($urandom_range(1, 2)) cycle();
                    rst = 0;
                end
                default: begin
                    lock = 0;
                    repeat ($urandom_range(30, 80)) cycle();
                    lock = 1;
                end
            endcase
            repeat ($urandom_range(0, 12)) cycle();
        end
        repeat (40) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
